keypad_scanner_4x4: RTL and testbench
=====================================

# keypad_scanner_4x4

Matrix keypad scanner for a 4x4 membrane keypad: drives one column low at a time, samples the four row lines, debounces across full scans and reports a single 4-bit key code with a one-cycle strobe. It is the input-side counterpart of the multiplexed 4-digit seven-segment display. The display scans outputs; this block scans inputs using the same time-multiplexed column dwell. Its `KeyCode` output feeds the display digit inputs directly.

## Interface
- `SCAN_TICKS`, default 250000: SysClk cycles each column is driven. Must be >= 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans needed to accept a press or a release. Must be >= 1.
- `SysClk`, in, 1: system clock. All logic is on the rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `Row`, in, 4: keypad row lines. Active-low (pulled up externally). Asynchronous to SysClk.
- `Col`, out, 4: column drive. Active-low, one-hot-zero (exactly one bit low).
- `KeyCode`, out, 4: accepted key, `{row_idx[1:0], col_idx[1:0]}`. Holds its value until the next accept.
- `KeyValid`, out, 1: one-cycle pulse when a new key is accepted.
- `KeyHeld`, out, 1: level. High from accept until the release is debounced.

## Operation
- `Row` passes through a 2-flop synchronizer before any use.
- Column counter `col_idx` runs 0,1,2,3,0,… and advances when the dwell counter reaches `SCAN_TICKS-1`. `Col = ~(4'b0001 << col_idx)`.
- Rows are sampled into a 16-bit key map on the last dwell cycle of each column. Bit index = `4*row_idx + col_idx`; a row reading 0 means pressed.
- A full scan completes on the col 3 sample. The scan result is then classified as one of:
  - NONE: zero bits set.
  - SINGLE(code): exactly one bit set.
  - MULTI: two or more bits set.
- State machine, updated once per completed scan:
  - IDLE:
    - SINGLE(c): capture candidate c, set cnt=1, go to PRESS_DB. If `DEBOUNCE_SCANS`=1, accept immediately instead.
    - Anything else: stay in IDLE.
  - PRESS_DB:
    - SINGLE(same c): cnt+1. When cnt reaches `DEBOUNCE_SCANS`, accept.
    - SINGLE(different c'): restart with candidate c', cnt=1.
    - NONE or MULTI: return to IDLE, cnt=0.
  - Accept: `KeyCode`<=c, `KeyValid` pulses, `KeyHeld`<=1, go to HELD.
  - HELD:
    - NONE: set cnt=1, go to RELEASE_DB.
    - SINGLE (any code) or MULTI: stay in HELD. No new strobe without a release first.
  - RELEASE_DB:
    - NONE: cnt+1. At `DEBOUNCE_SCANS`, clear `KeyHeld` and go to IDLE.
    - Any key seen: return to HELD.
- Counters saturate; they never wrap.

## Timing
- Reset values:
  - `Col`=4'b1110 (col 0 driven).
  - `KeyCode`=0, `KeyValid`=0, `KeyHeld`=0.
  - State IDLE; dwell, column and debounce counters 0; synchronizer flops and key map all 1 (idle-high rows).
- Full scan period is `4*SCAN_TICKS` cycles. The first scan ends on cycle `4*SCAN_TICKS-1` after Reset deasserts.
- Input-to-sample: a row change must be stable 2 cycles before a sample edge to be seen (synchronizer depth).
- Press latency: `KeyValid` rises the cycle after the `DEBOUNCE_SCANS`-th qualifying scan completes. `KeyCode` updates on that same edge.
- `KeyHeld` falls the cycle after the `DEBOUNCE_SCANS`-th NONE scan completes.
- Reset asserted mid-scan or mid-debounce:
  - All outputs go to their reset values immediately (asynchronously).
  - No `KeyValid` is generated for the interrupted press.
  - Scanning restarts at col 0 on deassert.

## Structure
- Package `keypad_pkg` holds:
  - State enum: IDLE, PRESS_DB, HELD, RELEASE_DB.
  - Scan-class enum: NONE, SINGLE, MULTI.
  - Constants `KP_ROWS`=4, `KP_COLS`=4, `KP_CODE_W`=4.
- Sub-module `scan_tick_gen`: dwell counter plus column counter. It outputs `col_idx` and `sample_en` (last dwell cycle) and `scan_done` (`sample_en` with col 3).
- The top level holds the synchronizer, key map, classifier, FSM and output registers.

## Test plan
All scenarios use `SCAN_TICKS`=4, `DEBOUNCE_SCANS`=2 (one full scan = 16 cycles).
- Reset check: no key pressed during and after reset.
  - During reset: `Col`=1110, outputs 0.
  - After release: `Col` steps 1110, 1101, 1011, 0111 every 4 cycles and wraps; `KeyValid` never pulses.
- Single press: hold the row 2 / col 1 key from reset deassert.
  - `KeyValid` pulses once at cycle 32, `KeyCode`=4'b1001, `KeyHeld`=1.
- Release: release that key at cycle 40.
  - `KeyHeld` falls after two NONE scans (cycle 80).
  - No extra `KeyValid`.
- Bounce: press key 0, open it for 4 cycles inside the second scan, then hold it.
  - The second scan classifies NONE and the FSM returns to IDLE.
  - Accept comes two clean scans later, not at cycle 32.
- Multi-key: press key 0 and key 5 together.
  - No `KeyValid` while both are held.
  - Releasing key 5 gives `KeyValid` with `KeyCode`=0 two scans later.
- Reset mid-debounce: assert `Reset` at cycle 20 while a key is held, deassert at 24.
  - Outputs clear immediately.
  - `KeyValid` arrives 32 cycles after deassert.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, constants and scan classifier for the 4x4 keypad scanner
package keypad_pkg;

  localparam int KP_ROWS   = 4;
  localparam int KP_COLS   = 4;
  localparam int KP_CODE_W = 4;
  localparam int KP_KEYS   = KP_ROWS * KP_COLS;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } kp_state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } scan_class_e;

  typedef struct packed {
    scan_class_e          cls;
    logic [KP_CODE_W-1:0] code;
  } scan_result_t;

  // Bit index 4*row+col equals the key code, so the index of the only set bit is the code.
  function automatic scan_result_t classify_scan(input logic [KP_KEYS-1:0] pressed);
    scan_result_t res;
    int unsigned  n;
    res.cls  = NONE;
    res.code = '0;
    n        = 0;
    for (int i = 0; i < KP_KEYS; i++) begin
      if (pressed[i]) begin
        n++;
        res.code = KP_CODE_W'(i);
      end
    end
    if (n == 1) begin
      res.cls = SINGLE;
    end else if (n > 1) begin
      res.cls = MULTI;
    end
    return res;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - column dwell timer and column index for the keypad scanner
module scan_tick_gen import keypad_pkg::*; #(
  parameter int SCAN_TICKS = 250000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [1:0] col_idx_o,
  output logic       sample_en_o,
  output logic       scan_done_o
);

  localparam int DW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_TICKS - 1);

  logic [DW-1:0] dwell_q;
  logic [DW-1:0] dwell_d;
  logic [1:0]    col_q;
  logic [1:0]    col_d;

  assign sample_en_o = (dwell_q == DWELL_LAST);
  assign scan_done_o = sample_en_o && (col_q == 2'(KP_COLS - 1));
  assign col_idx_o   = col_q;

  // Next dwell/column: the column index wraps 3 -> 0 by design, one step per dwell period.
  always_comb begin
    dwell_d = dwell_q + 1'b1;
    col_d   = col_q;
    if (sample_en_o) begin
      dwell_d = '0;
      col_d   = col_q + 1'b1;
    end
  end

  // Dwell and column registers, restarting at column 0 from reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dwell_q <= '0;
      col_q   <= '0;
    end else begin
      dwell_q <= dwell_d;
      col_q   <= col_d;
    end
  end

endmodule

// File: rtl/keypad_scanner_4x4.sv
// rtl/keypad_scanner_4x4.sv - 4x4 matrix keypad scanner with full-scan debounce and key strobe
module keypad_scanner_4x4 import keypad_pkg::*; #(
  parameter int SCAN_TICKS     = 250000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                 SysClk,
  input  logic                 Reset,
  input  logic [KP_ROWS-1:0]   Row,
  output logic [KP_COLS-1:0]   Col,
  output logic [KP_CODE_W-1:0] KeyCode,
  output logic                 KeyValid,
  output logic                 KeyHeld
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]           col_idx;
  logic                 sample_en;
  logic                 scan_done;
  logic [KP_ROWS-1:0]   sync1_q;
  logic [KP_ROWS-1:0]   sync2_q;
  logic [KP_KEYS-1:0]   key_map_q;
  logic [KP_KEYS-1:0]   key_map_d;
  scan_result_t         scan_res;
  kp_state_e            state_q;
  logic [KP_CODE_W-1:0] cand_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_inc;
  logic [KP_CODE_W-1:0] key_code_q;
  logic                 key_valid_q;
  logic                 key_held_q;

  scan_tick_gen #(
    .SCAN_TICKS (SCAN_TICKS)
  ) u_tick (
    .clk_i       (SysClk),
    .rst_i       (Reset),
    .col_idx_o   (col_idx),
    .sample_en_o (sample_en),
    .scan_done_o (scan_done)
  );

  assign Col      = ~(KP_COLS'(1) << col_idx);
  assign KeyCode  = key_code_q;
  assign KeyValid = key_valid_q;
  assign KeyHeld  = key_held_q;

  // Two-flop synchronizer for the asynchronous row lines; idles high like the pulled-up rows.
  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= Row;
      sync2_q <= sync1_q;
    end
  end

  // Merge the current column's rows into the map so the column-3 sample is part of this scan's verdict.
  always_comb begin
    key_map_d = key_map_q;
    if (sample_en) begin
      for (int r = 0; r < KP_ROWS; r++) begin
        for (int c = 0; c < KP_COLS; c++) begin
          if (col_idx == 2'(c)) begin
            key_map_d[r * KP_COLS + c] = sync2_q[r];
          end
        end
      end
    end
  end

  assign scan_res = classify_scan(~key_map_d);
  assign cnt_inc  = (cnt_q == DEB_MAX) ? cnt_q : cnt_q + 1'b1;

  // Raw row levels per key; a 0 means that key read as pressed.
  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      key_map_q <= '1;
    end else if (sample_en) begin
      key_map_q <= key_map_d;
    end
  end

  // Debounce FSM stepping once per completed scan, with registered key outputs.
  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (scan_done) begin
        case (state_q)
          IDLE: begin
            if (scan_res.cls == SINGLE) begin
              if (DEBOUNCE_SCANS == 1) begin
                key_code_q  <= scan_res.code;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                cnt_q       <= '0;
                state_q     <= HELD;
              end else begin
                cand_q  <= scan_res.code;
                cnt_q   <= CNT_ONE;
                state_q <= PRESS_DB;
              end
            end
          end
          PRESS_DB: begin
            if (scan_res.cls == SINGLE && scan_res.code == cand_q) begin
              if (cnt_inc == DEB_MAX) begin
                key_code_q  <= cand_q;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                cnt_q       <= '0;
                state_q     <= HELD;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else if (scan_res.cls == SINGLE) begin
              cand_q <= scan_res.code;
              cnt_q  <= CNT_ONE;
            end else begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end
          end
          HELD: begin
            if (scan_res.cls == NONE) begin
              if (DEBOUNCE_SCANS == 1) begin
                key_held_q <= 1'b0;
                cnt_q      <= '0;
                state_q    <= IDLE;
              end else begin
                cnt_q   <= CNT_ONE;
                state_q <= RELEASE_DB;
              end
            end
          end
          RELEASE_DB: begin
            if (scan_res.cls == NONE) begin
              if (cnt_inc == DEB_MAX) begin
                key_held_q <= 1'b0;
                cnt_q      <= '0;
                state_q    <= IDLE;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              cnt_q   <= '0;
              state_q <= HELD;
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// tb/tb_keypad_scanner_4x4.sv - self-checking bench for keypad_scanner_4x4 against a scan-level model
module tb_keypad_scanner_4x4;

  localparam int ST  = 4;
  localparam int DEB = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed;

  int checks   = 0;
  int failures = 0;

  // model state
  int          m_cnt;
  logic [15:0] h0, h1, h2, m_map;
  int          m_phase;   // 0 idle, 1 confirming press, 2 held, 3 confirming release
  int          m_cand;
  int          m_deb;
  logic [3:0]  exp_code;
  logic        exp_valid;
  logic        exp_held;

  // observation trackers
  int   first_valid;
  int   valid_cnt;
  int   held_fall;
  logic prev_held;

  always #5 clk = ~clk;

  keypad_scanner_4x4 #(
    .SCAN_TICKS     (ST),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .SysClk   (clk),
    .Reset    (rst),
    .Row      (row),
    .Col      (col),
    .KeyCode  (key_code),
    .KeyValid (key_valid),
    .KeyHeld  (key_held)
  );

  // Physical keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && pressed[4*r+c]) row[r] = 1'b0;
  end

  task automatic model_reset();
    m_cnt = 0; h0 = '0; h1 = '0; h2 = '0; m_map = '0;
    m_phase = 0; m_cand = 0; m_deb = 0;
    exp_code = '0; exp_valid = 1'b0; exp_held = 1'b0;
  endtask

  task automatic accept(input int code);
    exp_code = 4'(code); exp_valid = 1'b1; exp_held = 1'b1; m_phase = 2; m_deb = 0;
  endtask

  task automatic scan_eval();
    int n;
    int code;
    n = $countones(m_map);
    code = 0;
    for (int i = 0; i < 16; i++) if (m_map[i]) code = i;
    case (m_phase)
      0: if (n == 1) begin
        m_cand = code; m_deb = 1; m_phase = 1;
        if (m_deb >= DEB) accept(code);
      end
      1: if (n == 1 && code == m_cand) begin
        if (m_deb < DEB) m_deb++;
        if (m_deb >= DEB) accept(code);
      end else if (n == 1) begin
        m_cand = code; m_deb = 1;
      end else begin
        m_phase = 0; m_deb = 0;
      end
      2: if (n == 0) begin m_deb = 1; m_phase = 3; end
      default: if (n == 0) begin
        if (m_deb < DEB) m_deb++;
        if (m_deb >= DEB) begin exp_held = 1'b0; m_phase = 0; m_deb = 0; end
      end else begin
        m_phase = 2; m_deb = 0;
      end
    endcase
  endtask

  // One clock edge: a row is seen by the scanner as it stood two edges before its sample edge.
  task automatic model_edge();
    int c;
    if (rst) begin
      model_reset();
      return;
    end
    h2 = h1; h1 = h0; h0 = pressed;
    exp_valid = 1'b0;
    if (m_cnt % ST == ST - 1) begin
      c = (m_cnt / ST) % 4;
      for (int r = 0; r < 4; r++) m_map[4*r+c] = h2[4*r+c];
      if (c == 3) scan_eval();
    end
    m_cnt++;
  endtask

  task automatic check_outputs(input logic [3:0] e_col);
    checks++;
    assert (col === e_col) else begin
      failures++; $error("FAIL col cyc=%0d obs=%b exp=%b", m_cnt, col, e_col);
    end
    checks++;
    assert (key_valid === exp_valid) else begin
      failures++; $error("FAIL key_valid cyc=%0d obs=%b exp=%b", m_cnt, key_valid, exp_valid);
    end
    checks++;
    assert (key_code === exp_code) else begin
      failures++; $error("FAIL key_code cyc=%0d obs=%h exp=%h", m_cnt, key_code, exp_code);
    end
    checks++;
    assert (key_held === exp_held) else begin
      failures++; $error("FAIL key_held cyc=%0d obs=%b exp=%b", m_cnt, key_held, exp_held);
    end
  endtask

  task automatic step();
    logic [3:0] e_col;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    e_col = ~(4'b0001 << ((m_cnt / ST) % 4));
    check_outputs(e_col);
    if (key_valid === 1'b1) begin
      valid_cnt++;
      if (first_valid < 0) first_valid = m_cnt;
    end
    if (prev_held === 1'b1 && key_held === 1'b0 && held_fall < 0) held_fall = m_cnt;
    prev_held = key_held;
  endtask

  task automatic run_to(input int t);
    while (m_cnt < t) step();
  endtask

  // Assert reset between edges, check the asynchronous clear, hold for nhold edges, then release.
  task automatic do_reset(input int nhold);
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs(4'b1110);
    repeat (nhold) step();
    rst = 1'b0;
    first_valid = -1; valid_cnt = 0; held_fall = -1; prev_held = 1'b0;
  endtask

  task automatic expect_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++; $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int sel, k1, k2, dur;
    rst = 1'b1;
    pressed = '0;
    model_reset();
    first_valid = -1; valid_cnt = 0; held_fall = -1; prev_held = 1'b0;

    // idle keypad through and after reset
    repeat (3) step();
    rst = 1'b0;
    run_to(40);
    expect_int("idle_no_valid", valid_cnt, 0);

    // row 2 / col 1 held from deassert, released at cycle 40
    pressed = 16'h0200;
    do_reset(2);
    run_to(40);
    pressed = '0;
    run_to(100);
    expect_int("single_first_valid", first_valid, 32);
    expect_int("single_valid_count", valid_cnt, 1);
    expect_int("single_code", int'(key_code), 9);
    expect_int("release_fall", held_fall, 80);

    // bounce on key 0 during the second scan
    pressed = 16'h0001;
    do_reset(2);
    run_to(16);
    pressed = '0;
    run_to(20);
    pressed = 16'h0001;
    run_to(90);
    expect_int("bounce_first_valid", first_valid, 64);
    expect_int("bounce_valid_count", valid_cnt, 1);

    // keys 0 and 5 together, key 5 released at cycle 40
    pressed = 16'h0021;
    do_reset(2);
    run_to(40);
    expect_int("multi_no_valid", valid_cnt, 0);
    pressed = 16'h0001;
    run_to(100);
    expect_int("multi_first_valid", first_valid, 80);
    expect_int("multi_code", int'(key_code), 0);

    // reset interrupting the press debounce at cycle 20, released at 24
    pressed = 16'h8000;
    do_reset(2);
    run_to(20);
    expect_int("interrupted_no_valid", valid_cnt, 0);
    do_reset(4);
    run_to(50);
    expect_int("after_reset_first_valid", first_valid, 32);
    expect_int("after_reset_code", int'(key_code), 15);
    do_reset(1);

    // random key activity
    for (int it = 0; it < 70; it++) begin
      sel = int'($urandom_range(0, 19));
      k1  = int'($urandom_range(0, 15));
      k2  = int'($urandom_range(0, 15));
      dur = int'($urandom_range(3, 60));
      if (sel == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else if (sel < 6) begin
        pressed = '0;
      end else if (sel < 16) begin
        pressed = 16'(1) << k1;
      end else begin
        pressed = (16'(1) << k1) | (16'(1) << k2);
      end
      repeat (dur) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
